// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronizer, clock glitch filter, frame FSM with timeout, make/break/E0 decoder.
// Optional macro PS2_PARITY_CHECK_EN enables odd-parity enforcement; when undefined parity is ignored.
module ps2_key_decoder #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       f_key_pause,
  output logic       f_key_reset,
  output logic [3:0] lane_keys,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int NKEYS = 6;
  // Key order: pause, reset, lane D, lane F, lane J, lane K
  localparam logic [8*NKEYS-1:0] KEY_CODES = {8'h42, 8'h3B, 8'h2B, 8'h23, 8'h0B, 8'h03};

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [1:0]    r_clk_sync, r_data_sync;
  logic          r_filt, r_filt_d;
  logic [FW-1:0] r_filt_cnt;
  logic [TW-1:0] r_tmo;
  state_t        r_state, w_state_next;
  logic [7:0]    r_shift;
  logic [2:0]    r_bitcnt;
  logic          r_ext, r_brk;
  logic [NKEYS-1:0] r_keys;
  logic [NKEYS-1:0] w_hit;
  logic          w_clk_s, w_data, w_strobe, w_timeout, w_parity_ok;
  logic          w_byte_good, w_frame_bad, w_is_key;

  assign w_clk_s = r_clk_sync[1];
  assign w_data  = r_data_sync[1];

  // Lines idle high, so synchronizers and filter come out of reset at 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
      r_filt      <= 1'b1;
      r_filt_d    <= 1'b1;
      r_filt_cnt  <= '0;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], ps2_clk};
      r_data_sync <= {r_data_sync[0], ps2_data};
      r_filt_d    <= r_filt;
      if (w_clk_s == r_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
        r_filt     <= w_clk_s;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  assign w_strobe  = r_filt_d & ~r_filt;
  assign w_timeout = (r_state != S_IDLE) && (r_tmo == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo <= '0;
    end else if (r_state == S_IDLE || w_strobe || w_timeout) begin
      r_tmo <= '0;
    end else begin
      r_tmo <= r_tmo + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Timeout has priority over a coincident strobe
  always_comb begin
    w_state_next = r_state;
    if (w_timeout) begin
      w_state_next = S_IDLE;
    end else if (w_strobe) begin
      case (r_state)
        S_IDLE:   if (!w_data) w_state_next = S_DATA;
        S_DATA:   if (r_bitcnt == 3'd7) w_state_next = S_PARITY;
        S_PARITY: w_state_next = S_STOP;
        default:  w_state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_byte_good = 1'b0;
    w_frame_bad = w_timeout;
    if (!w_timeout && w_strobe && r_state == S_STOP) begin
      w_byte_good = w_data & w_parity_ok;
      w_frame_bad = ~(w_data & w_parity_ok);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift  <= '0;
      r_bitcnt <= '0;
    end else if (w_strobe && !w_timeout) begin
      if (r_state == S_IDLE) begin
        r_bitcnt <= '0;
      end else if (r_state == S_DATA) begin
        r_shift  <= {w_data, r_shift[7:1]};
        r_bitcnt <= r_bitcnt + 3'd1;
      end
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  logic r_parity;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_parity <= 1'b0;
    end else if (w_strobe && !w_timeout && r_state == S_PARITY) begin
      r_parity <= w_data;
    end
  end
  assign w_parity_ok = ^{r_shift, r_parity};
`else
  assign w_parity_ok = 1'b1;
`endif

  assign w_is_key = w_byte_good && (r_shift != 8'hE0) && (r_shift != 8'hF0) && !r_ext;

  genvar gi;
  generate
    for (gi = 0; gi < NKEYS; gi++) begin : g_key
      assign w_hit[gi] = w_is_key && (r_shift == KEY_CODES[gi*8 +: 8]);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_code  <= 8'h00;
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
      r_ext      <= 1'b0;
      r_brk      <= 1'b0;
      r_keys     <= '0;
    end else begin
      scan_valid <= w_byte_good;
      frame_err  <= w_frame_bad;
      r_keys     <= (r_keys & ~w_hit) | (w_hit & {NKEYS{~r_brk}});
      if (w_byte_good) begin
        scan_code <= r_shift;
        if (r_shift == 8'hE0) begin
          r_ext <= 1'b1;
        end else if (r_shift == 8'hF0) begin
          r_brk <= 1'b1;
        end else begin
          r_ext <= 1'b0;
          r_brk <= 1'b0;
        end
      end else if (w_frame_bad) begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end
    end
  end

  assign f_key_pause = r_keys[0];
  assign f_key_reset = r_keys[1];
  assign lane_keys   = r_keys[5:2];
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed scenarios plus random frames, checked every cycle against a byte-level model.
module tb_ps2_key_decoder;
  localparam int HALF = 20;
  localparam int TMO  = 1000;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       f_key_pause, f_key_reset, scan_valid, frame_err;
  logic [3:0] lane_keys;
  logic [7:0] scan_code;

  always #5 clk = ~clk;

  ps2_key_decoder #(.FILTER_LEN(8), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .f_key_pause(f_key_pause), .f_key_reset(f_key_reset), .lane_keys(lane_keys),
    .scan_code(scan_code), .scan_valid(scan_valid), .frame_err(frame_err)
  );

  typedef struct packed { logic err; logic [7:0] b; } ev_t;
  ev_t q[$];
  int n_checks = 0, n_fail = 0, n_valid = 0;
  logic [5:0] m_keys;
  logic [7:0] m_code;
  logic m_ext, m_brk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int key_index(input logic [7:0] b);
    case (b)
      8'h03: return 0;
      8'h0B: return 1;
      8'h23: return 2;
      8'h2B: return 3;
      8'h3B: return 4;
      8'h42: return 5;
      default: return -1;
    endcase
  endfunction

  function automatic void model_reset();
    q.delete();
    m_keys = '0; m_code = 8'h00; m_ext = 1'b0; m_brk = 1'b0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    int idx;
    m_code = b;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      idx = key_index(b);
      if (!m_ext && idx >= 0) m_keys[idx] = !m_brk;
      m_ext = 1'b0; m_brk = 1'b0;
    end
  endfunction

  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      check("pulse_exclusive", 32'(scan_valid & frame_err), 32'd0);
      if (scan_valid || frame_err) begin
        if (scan_valid) n_valid++;
        if (q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_pulse: got valid=%0d err=%0d expected none at %0t", scan_valid, frame_err, $time);
        end else begin
          e = q.pop_front();
          check("pulse_kind", 32'(frame_err), 32'(e.err));
          if (!e.err) model_byte(e.b);
          else begin m_ext = 1'b0; m_brk = 1'b0; end
        end
      end
      check("scan_code", 32'(scan_code), 32'(m_code));
      check("keys", 32'({lane_keys, f_key_reset, f_key_pause}), 32'(m_keys));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic v, input bit glitch);
    ps2_data = v;
    cyc(HALF/2);
    ps2_clk = 1'b0;
    cyc(HALF);
    ps2_clk = 1'b1;
    if (glitch) begin
      cyc(4); ps2_clk = 1'b0; cyc(3); ps2_clk = 1'b1; cyc(HALF/2 - 7);
    end else begin
      cyc(HALF/2);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par = 0, input bit bad_stop = 0, input bit glitch = 0);
    ev_t e;
    logic p;
    p = (~^b) ^ bad_par;
    e.err = bad_stop || (bad_par && PAR_EN);
    e.b = b;
    q.push_back(e);
    ps2_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch);
    ps2_bit(p, glitch);
    ps2_bit(!bad_stop, glitch);
    ps2_data = 1'b1;
    cyc(30);
  endtask

  task automatic send_partial(input int nbits, input bit expect_err);
    ev_t e;
    if (expect_err) begin
      e.err = 1'b1; e.b = 8'h00;
      q.push_back(e);
    end
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(1'($urandom_range(0, 1)), 1'b0);
    ps2_data = 1'b1;
  endtask

  logic [7:0] pool [10] = '{8'h03, 8'h0B, 8'h23, 8'h2B, 8'h3B, 8'h42, 8'hE0, 8'hF0, 8'hAA, 8'hFA};

  initial begin
    int v0;
    logic [7:0] b;
    model_reset();
    rst = 1'b1;
    cyc(3);
    check("reset_keys", 32'({lane_keys, f_key_reset, f_key_pause}), 32'd0);
    check("reset_code", 32'(scan_code), 32'd0);
    check("reset_pulses", 32'({scan_valid, frame_err}), 32'd0);
    rst = 1'b0;
    cyc(5);

    v0 = n_valid;
    send_frame(8'h03);
    check("pause_press", 32'(f_key_pause), 32'd1);
    check("code_03", 32'(scan_code), 32'h03);
    send_frame(8'hF0);
    check("pause_held_after_f0", 32'(f_key_pause), 32'd1);
    send_frame(8'h03);
    check("pause_release", 32'(f_key_pause), 32'd0);
    check("valid_count", 32'(n_valid - v0), 32'd3);

    send_frame(8'h23);
    check("lanes_d", 32'(lane_keys), 32'b0001);
    send_frame(8'h42);
    check("lanes_dk", 32'(lane_keys), 32'b1001);
    send_frame(8'hF0); send_frame(8'h23);
    check("lanes_k", 32'(lane_keys), 32'b1000);
    send_frame(8'hF0); send_frame(8'h42);

    send_frame(8'hE0); send_frame(8'h0B);
    check("ext_no_reset", 32'(f_key_reset), 32'd0);
    check("ext_code", 32'(scan_code), 32'h0B);
    send_frame(8'h0B);
    check("reset_press", 32'(f_key_reset), 32'd1);
    send_frame(8'hF0); send_frame(8'h0B);
    check("reset_release", 32'(f_key_reset), 32'd0);

    send_frame(8'h0B, 1'b1);
    check("bad_parity_reset", 32'(f_key_reset), 32'(!PAR_EN));
    send_frame(8'hF0); send_frame(8'h0B);

    send_partial(4, 1'b1);
    cyc(TMO + 100);
    send_frame(8'h2B);
    check("after_timeout_lane_f", 32'(lane_keys[1]), 32'd1);

    ps2_data = 1'b0;
    repeat (5) begin
      ps2_clk = 1'b0; cyc(3); ps2_clk = 1'b1; cyc(10);
    end
    ps2_data = 1'b1;
    cyc(TMO + 100);
    send_frame(8'h3B, 1'b0, 1'b0, 1'b1);
    check("glitch_frame_lane_j", 32'(lane_keys[2]), 32'd1);

    for (int i = 0; i < 40; i++) begin
      b = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 9)];
      send_frame(b, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
    end

    send_frame(8'h23);
    send_partial(5, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_keys", 32'({lane_keys, f_key_reset, f_key_pause}), 32'd0);
    check("async_rst_code", 32'(scan_code), 32'd0);
    check("async_rst_pulses", 32'({scan_valid, frame_err}), 32'd0);
    model_reset();
    cyc(3);
    rst = 1'b0;
    cyc(TMO + 100);
    send_frame(8'h42);
    check("post_reset_lane_k", 32'(lane_keys[3]), 32'd1);

    cyc(20);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
